// File: rtl/md_scheduler_pkg.sv
// Shared multiply/divide definitions for the E-stage HI/LO unit.
// Holds the md_op encodings driven by decode, the sequencer state type
// and small decode helpers used by md_scheduler and md_compute.
package md_scheduler_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    // True for the ops that go through the multi-cycle countdown.
    function automatic logic is_md_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_md_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath.
// Ports:
//   md_op  - operation code (md_scheduler_pkg encodings)
//   md_a   - rs operand (dividend / multiplicand)
//   md_b   - rt operand (divisor / multiplier)
//   result - {hi, lo}; product for mult, {remainder, quotient} for div.
//            Zero for any non-arithmetic op.
module md_compute
    import md_scheduler_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    output logic [63:0] result
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic               div_zero;
    logic               div_ovf;

    assign a_sx   = {{32{md_a[31]}}, md_a};
    assign b_sx   = {{32{md_b[31]}}, md_b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'h0, md_a} * {32'h0, md_b};

    // The raw dividers are only consumed when the divisor is non-zero and
    // the signed case is not the single overflowing pair; both corner
    // results are substituted below.
    assign quot_s = $signed(md_a) / $signed(md_b);
    assign rem_s  = $signed(md_a) % $signed(md_b);
    assign quot_u = md_a / md_b;
    assign rem_u  = md_a % md_b;

    assign div_zero = (md_b == 32'h0);
    assign div_ovf  = (md_a == 32'h8000_0000) && (md_b == 32'hFFFF_FFFF);

    always_comb begin
        result = '0;
        case (md_op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV: begin
                if (div_zero)
                    result = {md_a, 32'hFFFF_FFFF};
                else if (div_ovf)
                    result = {32'h0, 32'h8000_0000};
                else
                    result = {rem_s, quot_s};
            end
            MD_DIVU: begin
                if (div_zero)
                    result = {md_a, 32'hFFFF_FFFF};
                else
                    result = {rem_u, quot_u};
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/md_scheduler.sv
// Multiply/divide sequencer beside the E-stage ALU; owns HI/LO.
// An accepted mult/div latches its result immediately and commits it to
// HI/LO after a fixed down-counted latency; mthi/mtlo write directly.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | counter == 0, ready to accept; mthi/mtlo write HI/LO
// ST_RUN  | counter > 0, result pending; commit when counter hits 0
//
// Ports:
//   clk       - core clock
//   reset     - synchronous active-high reset
//   md_op     - E-stage op code
//   md_a/md_b - forwarded rs/rt operands
//   flush     - E-stage instruction cancelled; blocks acceptance
//   hilo_read - mfhi/mflo in E this cycle
//   busy      - operation in flight
//   stall     - freeze F/D/E while a HI/LO user meets a busy unit
//   hi/lo     - architectural HI/LO registers
module md_scheduler
    import md_scheduler_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic        flush,
    input  logic        hilo_read,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    md_state_t          state;
    md_state_t          state_nxt;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic [63:0]        pend;
    logic [63:0]        pend_nxt;
    logic [31:0]        hi_nxt;
    logic [31:0]        lo_nxt;
    logic [63:0]        md_result;
    logic [CNT_W-1:0]   lat_load;

    md_compute u_compute (
        .md_op  (md_op),
        .md_a   (md_a),
        .md_b   (md_b),
        .result (md_result)
    );

    assign lat_load = is_md_div(md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

    assign busy  = (state == ST_RUN);
    assign stall = busy && (hilo_read || (md_op != MD_NONE));

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        pend_nxt  = pend;
        hi_nxt    = hi;
        lo_nxt    = lo;
        case (state)
            ST_IDLE: begin
                if (!flush) begin
                    if (is_md_arith(md_op)) begin
                        state_nxt = ST_RUN;
                        count_nxt = lat_load;
                        pend_nxt  = md_result;
                    end else if (md_op == MD_MTHI) begin
                        hi_nxt = md_a;
                    end else if (md_op == MD_MTLO) begin
                        lo_nxt = md_a;
                    end
                end
            end
            ST_RUN: begin
                // flush is ignored here: the in-flight op already retired.
                count_nxt = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                    hi_nxt    = pend[63:32];
                    lo_nxt    = pend[31:0];
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
            pend  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            pend  <= pend_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
        end
    end

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
- Multiply/divide sequencer for the pipelined MIPS core; sits beside the E-stage ALU and owns the HI/LO registers.
- Accepts mult/multu/div/divu/mthi/mtlo issued from E and models multi-cycle latency with a countdown.
- Commits results to HI/LO and raises a pipeline stall while any HI/LO consumer or new MD op meets a busy unit.

Parameters:
- MUL_LAT, 5, cycles from accepted mult/multu to HI/LO commit (must be ≥1).
- DIV_LAT, 10, cycles from accepted div/divu to HI/LO commit (must be ≥1).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- md_op  input  3  E-stage op: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO (codes in shared header).
- md_a  input  32  rs operand (E stage, forwarded).
- md_b  input  32  rt operand (E stage, forwarded).
- flush  input  1  E-stage instruction cancelled (exception/eret); suppresses acceptance this cycle.
- hilo_read  input  1  mfhi/mflo present in E stage this cycle.
- busy  output  1  operation in flight.
- stall  output  1  freeze F/D/E, bubble into M.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: busy=0, stall=0, hi=0, lo=0, counter=0, pending result=0. Reset mid-operation discards the in-flight op; there is no commit.
- States: IDLE (counter==0) and RUN (counter>0). busy = (state==RUN).
- Accept condition at edge T: md_op in {MULT,MULTU,DIV,DIVU} && !busy && !flush. Computed 64-bit result latched into pending_hi/pending_lo at T; counter loaded with MUL_LAT or DIV_LAT.
- RUN: counter decrements every edge. At the edge where counter goes 1→0, hi<=pending_hi, lo<=pending_lo, busy falls. busy is high for exactly LAT cycles after T.
- MTHI/MTLO: accepted when !busy && !flush; hi (or lo) <= md_a at that edge, zero latency, no RUN.
- stall (combinational) = busy && (hilo_read || md_op != NONE). An op presented while busy is not accepted; upstream holds it until stall drops. It is accepted on the first cycle busy=0.
- Commit/read boundary: in the cycle busy falls, hi/lo already hold the new value, so mfhi/mflo reads the committed result with no stall.
- flush with a new op: op ignored, no state change. flush during RUN: the in-flight op continues and commits (it retired earlier).
- mult: signed 32x32→64; multu: unsigned. hi = product[63:32], lo = product[31:0].
- div/divu: lo = quotient, hi = remainder; signed truncates toward zero, remainder takes the dividend's sign.
- Divide by zero (either signedness): lo = 0xFFFFFFFF, hi = md_a.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- md_op=NONE: no effect.

Decomposition:
- Shared header (alongside existing control constants): MD_NONE/MD_MULT/MD_MULTU/MD_DIV/MD_DIVU/MD_MTHI/MD_MTLO encodings. The decode-stage control generates md_op from these.
- One sub-module, md_compute: purely combinational. Inputs md_op, md_a, md_b; output 64-bit {hi,lo} result, including the div-by-zero and overflow rules.
- md_scheduler holds the counter, busy/stall logic and HI/LO registers.

Test Plan:
- MULT a=0xFFFFFFFE (−2), b=3 at T -> busy high cycles T+1..T+5; at T+5 hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy=0 after.
- DIVU a=100, b=7 then hilo_read held from T+1 -> stall=1 for 10 cycles, then lo=14, hi=2, stall=0 with read same cycle.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIV a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
- MULTU issued while busy (op held) -> stall=1, ignored until busy falls, then accepted; second result commits MUL_LAT cycles later. MTHI 0x1234 when idle -> hi=0x1234 next edge, busy stays 0.
- MULT with flush=1 -> no acceptance, hi/lo unchanged. flush during RUN -> commit still occurs on schedule.
- reset asserted at cycle 3 of a DIV -> next edge busy=0, hi=lo=0, no later commit.
